// File: rtl/csi_rx_pkg.sv
// Shared types for the CSI-2 receive path.
// Bank and reader state encodings, default line RAM address width.
package csi_rx_pkg;

  localparam int LB_ADDR_W = 11;

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_FULL,
    B_DRAINING
  } bank_state_t;

  typedef enum logic {
    R_IDLE,
    R_READ
  } rd_state_t;

endpackage

// File: rtl/lb_bank_state.sv
// One line RAM bank's occupancy state and stored line length.
// Ports: claim/close from writer, start/release from reader,
//        abort from frame_start; state_o/len_o report the bank.
module lb_bank_state
  import csi_rx_pkg::*;
#(
  parameter int ADDR_W = LB_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              claim_i,
  input  logic              close_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              start_i,
  input  logic              release_i,
  input  logic              abort_i,
  output bank_state_t       state_o,
  output logic [ADDR_W:0]   len_o
);

  bank_state_t       state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;

  // Claim outranks release/abort so a bank freed this
  // cycle can be refilled in the same cycle.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (claim_i) begin
      state_d = close_i ? B_FULL : B_FILLING;
      if (close_i) len_d = len_i;
    end else if (close_i) begin
      state_d = B_FULL;
      len_d   = len_i;
    end else if (release_i) begin
      state_d = B_EMPTY;
    end else if (start_i) begin
      state_d = B_DRAINING;
    end else if (abort_i) begin
      state_d = B_EMPTY;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= B_EMPTY;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  assign state_o = state_q;
  assign len_o   = len_q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Ping-pong line buffer controller: fills one RAM bank, drains the other.
// Ports: wr_* steer unpacked bytes, rd_*/out_* drain, overflow is sticky.
module line_buffer_ctrl
  import csi_rx_pkg::*;
#(
  parameter int ADDR_W = LB_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              line_end,
  input  logic              frame_start,
  input  logic              rd_ready,
  output logic              wr_we,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_re,
  output logic              rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              out_valid,
  output logic              out_line_start,
  output logic              out_line_end,
  output logic              overflow
);

  bank_state_t       bank_st  [2];
  logic [ADDR_W:0]   bank_len [2];

  logic [1:0]        claim, close_b, start, rel, abort;
  logic [ADDR_W:0]   close_len;

  // Writer state
  logic              wr_sel_q, wr_sel_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
  logic              in_line_q, in_line_d;
  logic              drop_q, drop_d;
  logic              ovf_q, ovf_d;

  // Reader state
  rd_state_t         rd_st_q;
  logic              rd_sel_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              ov_q, ols_q, ole_q;

  logic              rd_go, rd_last, rd_claim;
  logic              first, avail, claim_ok, first_drop;
  logic              cont, cont_ok, cont_drop, filling, close;
  logic [ADDR_W:0]   cnt_nx;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    lb_bank_state #(.ADDR_W(ADDR_W)) u_bank (
      .clk_i     (clk),
      .rst_i     (reset),
      .claim_i   (claim[b]),
      .close_i   (close_b[b]),
      .len_i     (close_len),
      .start_i   (start[b]),
      .release_i (rel[b]),
      .abort_i   (abort[b]),
      .state_o   (bank_st[b]),
      .len_o     (bank_len[b])
    );
  end

  // Reader: a FULL bank is picked up and read in the same cycle.
  always_comb begin
    rd_claim = (rd_st_q == R_IDLE)
             && (bank_st[rd_sel_q] == B_FULL);
    rd_go    = (rd_st_q == R_READ) || rd_claim;
    rd_re    = rd_go && rd_ready;
    rd_last  = rd_re && ({1'b0, rd_addr_q}
             == bank_len[rd_sel_q] - (ADDR_W+1)'(1));
    start    = 2'b00;
    rel      = 2'b00;
    start[rd_sel_q] = rd_claim;
    rel[rd_sel_q]   = rd_last;
  end

  // Writer: a line is either in a claimed bank or being dropped.
  always_comb begin
    first      = wr_en && (frame_start || !(in_line_q || drop_q));
    abort      = 2'b00;
    abort[wr_sel_q] = frame_start && in_line_q;
    avail      = (bank_st[wr_sel_q] == B_EMPTY)
              || rel[wr_sel_q] || abort[wr_sel_q];
    claim_ok   = first && avail;
    first_drop = first && !avail;
    cont       = wr_en && in_line_q && !frame_start;
    cont_ok    = cont && !wr_cnt_q[ADDR_W];
    cont_drop  = cont && wr_cnt_q[ADDR_W];
    filling    = claim_ok || (in_line_q && !frame_start);
    close      = line_end && filling;

    if (claim_ok)
      cnt_nx = (ADDR_W+1)'(1);
    else if (frame_start)
      cnt_nx = '0;
    else
      cnt_nx = wr_cnt_q + (ADDR_W+1)'(cont_ok);

    close_len = cnt_nx;
    claim     = 2'b00;
    close_b   = 2'b00;
    claim[wr_sel_q]   = claim_ok;
    close_b[wr_sel_q] = close;

    wr_sel_d  = close ? ~wr_sel_q : wr_sel_q;
    wr_cnt_d  = close ? '0 : cnt_nx;
    in_line_d = filling && !close;
    drop_d    = (first_drop || (drop_q && !frame_start))
             && !line_end;
    ovf_d     = (ovf_q && !frame_start)
             || first_drop || cont_drop;
  end

  assign wr_we   = claim_ok || cont_ok;
  assign wr_sel  = wr_sel_q;
  assign wr_addr = claim_ok ? '0 : wr_cnt_q[ADDR_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_sel_q  <= 1'b0;
      wr_cnt_q  <= '0;
      in_line_q <= 1'b0;
      drop_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_sel_q  <= wr_sel_d;
      wr_cnt_q  <= wr_cnt_d;
      in_line_q <= in_line_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_st_q   <= R_IDLE;
      rd_sel_q  <= 1'b0;
      rd_addr_q <= '0;
      ov_q      <= 1'b0;
      ols_q     <= 1'b0;
      ole_q     <= 1'b0;
    end else begin
      if (rd_last) begin
        rd_st_q   <= R_IDLE;
        rd_sel_q  <= ~rd_sel_q;
        rd_addr_q <= '0;
      end else if (rd_go) begin
        rd_st_q <= R_READ;
        if (rd_re) rd_addr_q <= rd_addr_q + ADDR_W'(1);
      end
      ov_q  <= rd_re;
      ols_q <= rd_re && (rd_addr_q == '0);
      ole_q <= rd_last;
    end
  end

  assign rd_sel         = rd_sel_q;
  assign rd_addr        = rd_addr_q;
  assign out_valid      = ov_q;
  assign out_line_start = ols_q;
  assign out_line_end   = ole_q;
  assign overflow       = ovf_q;

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Ping-pong line-buffer controller between the byte-to-pixel unpacker and the transmit side of the CSI-2 receive path. It steers unpacked pixel bytes into one of two external line RAM banks and drains the other bank to the downstream consumer under a ready handshake. It tracks per-bank occupancy and line length, and drops whole lines on overflow. It replaces ad-hoc line selection with an explicit fill/drain schedule.

## Interface
- ADDR_W, 11, line RAM address width; bank depth DEPTH = 2**ADDR_W bytes
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- wr_en  in  1  unpacked byte valid this cycle
- line_end  in  1  current byte (or, if wr_en=0, previous byte) closes the line
- frame_start  in  1  pulse; clears overflow, aborts a partially filled line
- rd_ready  in  1  downstream can accept a byte this cycle
- wr_we  out  1  RAM write strobe (combinational from wr_en and accept logic)
- wr_sel  out  1  bank being written
- wr_addr  out  ADDR_W  write address
- rd_re  out  1  RAM read strobe
- rd_sel  out  1  bank being read
- rd_addr  out  ADDR_W  read address
- out_valid  out  1  RAM read data valid (rd_re delayed 1 cycle)
- out_line_start  out  1  with out_valid on first byte of a line
- out_line_end  out  1  with out_valid on last byte of a line
- overflow  out  1  sticky; a byte or line was dropped since last frame_start

## Operation
- Per-bank state: EMPTY, FILLING, FULL, DRAINING; per-bank length register (ADDR_W+1 bits, 1..DEPTH).
- Writer: first byte of a line claims bank wr_sel if EMPTY -> FILLING, wr_addr=0. Each accepted byte: wr_we=1, wr_addr increments. On line_end: bank -> FULL, length=byte count, wr_sel toggles, wr_addr=0.
- Bank not EMPTY when a line's first byte arrives: whole line dropped (wr_we=0) until line_end; overflow=1; wr_sel unchanged.
- Byte count reaches DEPTH before line_end: further bytes dropped, overflow=1; line closes at line_end with length=DEPTH.
- line_end with zero bytes written for the line: ignored.
- Reader FSM R_IDLE -> R_READ when bank rd_sel is FULL (bank -> DRAINING, rd_addr=0). In R_READ, rd_re = rd_ready; each rd_re advances rd_addr. rd_re on address length-1: bank -> EMPTY, rd_sel toggles, FSM -> R_IDLE.
- A bank released (DRAINING->EMPTY) in cycle N may be claimed by a first byte in cycle N (same-cycle bypass).
- frame_start: FILLING bank -> EMPTY, writer count cleared, overflow=0; FULL/DRAINING banks unaffected. frame_start together with wr_en: the byte is the first byte of a new line.

## Timing
- Reset: all outputs 0, both banks EMPTY, wr_sel=rd_sel=0, reader R_IDLE.
- Write path: zero latency; wr_we/wr_addr valid in the wr_en cycle.
- line_end at cycle N -> bank FULL at N+1 -> first rd_re at N+1 if rd_ready -> out_valid at N+2.
- RAM read latency is 1 cycle; out_line_start/out_line_end aligned with out_valid.
- rd_ready low stalls rd_addr; no bubble on resume.
- Reset mid-line or mid-drain: everything returns to reset state immediately; in-flight data lost.

## Structure
- Shared package (csi_rx_pkg): bank_state_t enum, rd_state_t enum, ADDR_W default.
- Sub-module lb_bank_state, instantiated twice: holds one bank's state and length; inputs claim/close/start/release/abort.

## Test plan
- Reset, write 16 bytes with line_end on byte 16 -> wr_addr 0..15 on bank 0; bank 0 drains 16 bytes, out_line_start on byte 0, out_line_end on byte 15, first out_valid 2 cycles after line_end.
- Three back-to-back 8-byte lines, rd_ready=0 -> lines 1/2 stored in banks 0/1, line 3 dropped, overflow=1; raising rd_ready drains exactly 16 bytes.
- Line of DEPTH+5 bytes -> DEPTH bytes written, overflow=1, drained length=DEPTH.
- Bank 0's last rd_re coincides with a new line's first byte, bank 1 FULL -> byte written to bank 0, no drop.
- frame_start in the middle of a 10-byte line after 4 bytes -> bank returns EMPTY, overflow cleared, next line writes from addr 0.
- rd_ready toggling every cycle during a 12-byte drain -> 12 out_valid pulses, addresses 0..11 in order.
